// File: rtl/ppu_vga_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : ppu_vga_scanout
//  Description : Double-buffered framebuffer front end for the PPU.
//                - Write path: accepts PPU pixel writes (256x240) and forwards
//                  them, one clk later, into the back half of an external
//                  framebuffer RAM.
//                - Scan path: reads the front half out as 640x480@60 VGA with
//                  2x scaling (512x480 centred, 64-pixel side borders).
//                - Buffers swap at the start of vertical blank, but only once
//                  the PPU has written the last pixel of a frame.
//                - vga_done tells the PPU that vertical blank has begun and
//                  that any pending swap has taken effect.
//  Ports       : clk, rst (async, active-low)
//                vga_row/vga_col/vga_data/vga_write_en : PPU pixel writes
//                vga_done                              : vblank indicator
//                fb_wr_en/fb_wr_addr/fb_wr_data        : RAM write port
//                fb_rd_addr/fb_rd_data                 : RAM read port (1 clk)
//                hsync/vsync/de/pix_idx                : VGA pixel stream
//                swap_pulse                            : display buffer toggled
//  Revision    : 1.0 - initial release
// ============================================================================
module ppu_vga_scanout #(
    parameter int         PIX_DIV    = 2,      // clk cycles per VGA pixel, >= 2
    parameter logic [7:0] BORDER_IDX = 8'h0F,  // colour index of side borders
    // Raster geometry; defaults give standard 640x480@60 timing.
    parameter int         H_ACTIVE   = 640,
    parameter int         H_FRONT    = 16,
    parameter int         H_SYNC     = 96,
    parameter int         H_BACK     = 48,
    parameter int         H_BORDER   = 64,
    parameter int         V_ACTIVE   = 480,
    parameter int         V_FRONT    = 10,
    parameter int         V_SYNC     = 2,
    parameter int         V_BACK     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  vga_row,
    input  logic [8:0]  vga_col,
    input  logic [7:0]  vga_data,
    input  logic        vga_write_en,
    output logic        vga_done,
    output logic        fb_wr_en,
    output logic [16:0] fb_wr_addr,
    output logic [7:0]  fb_wr_data,
    output logic [16:0] fb_rd_addr,
    input  logic [7:0]  fb_rd_data,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [7:0]  pix_idx,
    output logic        swap_pulse
);

    localparam int               DIV_W        = $clog2(PIX_DIV);
    localparam logic [DIV_W-1:0] C_DIV_LAST   = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0]       C_H_ACTIVE   = 10'(H_ACTIVE);
    localparam logic [9:0]       C_H_TOTAL    = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [9:0]       C_HS_START   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0]       C_HS_END     = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0]       C_WIN_START  = 10'(H_BORDER);
    localparam logic [9:0]       C_WIN_END    = 10'(H_ACTIVE - H_BORDER);
    localparam logic [9:0]       C_V_ACTIVE   = 10'(V_ACTIVE);
    localparam logic [9:0]       C_V_TOTAL    = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [9:0]       C_VS_START   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0]       C_VS_END     = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    // ------------------------------------------------------------------
    // Pixel clock enable and raster counters
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_h_cnt;
    logic [9:0]       r_v_cnt;
    logic [9:0]       w_v_next;
    logic             w_pix_ce;
    logic             w_h_last;
    logic             w_line_end;

    assign w_pix_ce   = (r_div == C_DIV_LAST);
    assign w_h_last   = (r_h_cnt == C_H_TOTAL - 10'd1);
    assign w_line_end = w_pix_ce && w_h_last;
    assign w_v_next   = (r_v_cnt == C_V_TOTAL - 10'd1) ? 10'd0 : r_v_cnt + 10'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (w_pix_ce) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else if (w_pix_ce) begin
            r_h_cnt <= w_h_last ? 10'd0 : r_h_cnt + 10'd1;
            if (w_h_last) begin
                r_v_cnt <= w_v_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame handshake: completion flag, buffer swap, vga_done
    // ------------------------------------------------------------------
    logic r_disp_buf;
    logic r_frame_complete;
    logic r_vga_done;
    logic r_swap_pulse;
    logic w_wr_accept;
    logic w_wr_last;
    logic w_swap;

    assign w_wr_accept = vga_write_en && (vga_row < 9'd240) && (vga_col < 9'd256);
    assign w_wr_last   = w_wr_accept && (vga_row == 9'd239) && (vga_col == 9'd255);

    // The swap looks at the flag as it stood before this edge, so a
    // completing write landing on the swap edge itself waits a whole frame.
    assign w_swap = w_line_end && (r_v_cnt == C_V_ACTIVE - 10'd1) && r_frame_complete;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_disp_buf       <= 1'b0;
            r_frame_complete <= 1'b0;
            r_swap_pulse     <= 1'b0;
            r_vga_done       <= 1'b0;
        end else begin
            r_swap_pulse <= w_swap;
            if (w_swap) begin
                r_disp_buf <= ~r_disp_buf;
            end
            if (w_wr_last) begin
                r_frame_complete <= 1'b1;
            end else if (w_swap) begin
                r_frame_complete <= 1'b0;
            end
            // Rises on the same edge as any swap, so writes the PPU issues
            // after seeing it already target the new back buffer.
            if (w_line_end) begin
                r_vga_done <= (w_v_next >= C_V_ACTIVE);
            end
        end
    end

    // ------------------------------------------------------------------
    // Write path: one register stage into the back buffer
    // ------------------------------------------------------------------
    logic        r_fb_wr_en;
    logic [16:0] r_fb_wr_addr;
    logic [7:0]  r_fb_wr_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fb_wr_en   <= 1'b0;
            r_fb_wr_addr <= 17'd0;
            r_fb_wr_data <= 8'd0;
        end else begin
            r_fb_wr_en <= w_wr_accept;
            if (w_wr_accept) begin
                r_fb_wr_addr <= {~r_disp_buf, vga_row[7:0], vga_col[7:0]};
                r_fb_wr_data <= vga_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: address straight from the live counters, 2x downscaled
    // ------------------------------------------------------------------
    logic [9:0] w_x;
    logic       w_in_window;
    logic       w_unused_bits;

    assign w_x         = r_h_cnt - C_WIN_START;
    assign w_in_window = (r_h_cnt >= C_WIN_START) && (r_h_cnt < C_WIN_END) &&
                         (r_v_cnt < C_V_ACTIVE);
    assign fb_rd_addr  = w_in_window ? {r_disp_buf, r_v_cnt[8:1], w_x[8:1]} : 17'd0;

    // Only bits [8:1] feed the address; the rest are intentionally dropped.
    assign w_unused_bits = ^{r_v_cnt[9], r_v_cnt[0], w_x[9], w_x[0]};

    // ------------------------------------------------------------------
    // Output stage
    // The counter values seen by the RAM are captured on the pix_ce edge
    // and decoded one clk later, when the RAM data for that same address
    // is on fb_rd_data. Every output thus carries the same latency.
    // ------------------------------------------------------------------
    logic       r_ce_d;
    logic [9:0] r_h_q;
    logic [9:0] r_v_q;
    logic       w_q_visible;
    logic       w_q_window;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_de;
    logic [7:0] r_pix_idx;

    assign w_q_visible = (r_h_q < C_H_ACTIVE) && (r_v_q < C_V_ACTIVE);
    assign w_q_window  = w_q_visible && (r_h_q >= C_WIN_START) && (r_h_q < C_WIN_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ce_d <= 1'b0;
            r_h_q  <= 10'd0;
            r_v_q  <= 10'd0;
        end else begin
            r_ce_d <= w_pix_ce;
            if (w_pix_ce) begin
                r_h_q <= r_h_cnt;
                r_v_q <= r_v_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_de      <= 1'b0;
            r_pix_idx <= 8'd0;
        end else if (r_ce_d) begin
            r_de    <= w_q_visible;
            r_hsync <= !((r_h_q >= C_HS_START) && (r_h_q < C_HS_END));
            r_vsync <= !((r_v_q >= C_VS_START) && (r_v_q < C_VS_END));
            if (!w_q_visible) begin
                r_pix_idx <= 8'd0;
            end else if (w_q_window) begin
                r_pix_idx <= fb_rd_data;
            end else begin
                r_pix_idx <= BORDER_IDX;
            end
        end
    end

    assign vga_done   = r_vga_done;
    assign swap_pulse = r_swap_pulse;
    assign fb_wr_en   = r_fb_wr_en;
    assign fb_wr_addr = r_fb_wr_addr;
    assign fb_wr_data = r_fb_wr_data;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign de         = r_de;
    assign pix_idx    = r_pix_idx;

endmodule
`default_nettype wire
